// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes, FSM states,
// the default bus timeout, and small decode functions used by the top level.
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int LSU_TIMEOUT_DEFAULT = 255;

    // Unsigned variants exist only for loads; stores accept B/H/W.
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = is_load;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte offset actually used for lane steering: halfwords drop bit 0,
    // words drop both bits. Harmless when misalignment is trapped, since a
    // misaligned access never reaches the bus in that build.
    function automatic logic [1:0] eff_lo(input logic [2:0] f3, input logic [1:0] lo);
        logic [1:0] r;
        case (f3[1:0])
            2'b00:   r = lo;
            2'b01:   r = {lo[1], 1'b0};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic r;
        case (f3[1:0])
            2'b01:   r = lo[0];
            2'b10:   r = |lo;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and store replication for the
// outgoing request, and shift plus sign/zero extension for returning loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_st_f3,
    input  logic [1:0]  i_st_lo,
    input  logic        i_st_read,
    input  logic [31:0] i_wr_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_ld_f3,
    input  logic [1:0]  i_ld_lo,
    input  logic [31:0] i_rd_data,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_shifted;

    // Byte enables by access size; store data replicated across all lanes.
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'h0;
        case (i_st_f3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_st_lo;
                o_wdata = {4{i_wr_data[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << {i_st_lo[1], 1'b0};
                o_wdata = {2{i_wr_data[15:0]}};
            end
            2'b10: begin
                o_be    = 4'b1111;
                o_wdata = i_wr_data;
            end
            default: begin
                o_be    = 4'b0000;
                o_wdata = 32'h0;
            end
        endcase
        if (i_st_read) begin
            o_wdata = 32'h0;
        end
    end

    assign w_shifted = i_rd_data >> {i_ld_lo, 3'b000};

    // Extend the addressed byte/halfword; words arrive with a zero offset.
    always_comb begin
        o_ld_data = 32'h0;
        case (i_ld_f3)
            F3_B:    o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_ld_data = w_shifted;
            F3_BU:   o_ld_data = {24'h0, w_shifted[7:0]};
            F3_HU:   o_ld_data = {16'h0, w_shifted[15:0]};
            default: o_ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: takes the ALU result as address and rs2 as store data,
// runs one req/ack transaction to data memory and stalls the core meanwhile.
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned halfword/word
// accesses as errors; otherwise they are silently aligned.
//
// state | meaning
// IDLE  | no access in flight; a request is decoded here
// REQ   | bus request driven, waiting for DmAck or timeout
// DONE  | one-cycle completion pulse, inputs ignored
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] LoadData,
    output logic        LsuErr,
    output logic        DmReq,
    output logic        DmWe,
    output logic [31:0] DmAddr,
    output logic [3:0]  DmBe,
    output logic [31:0] DmWData,
    input  logic        DmAck,
    input  logic [31:0] DmRData
);

    // Counter only needs to reach TIMEOUT-1: the REQ cycle holding that value
    // is the last one before the timeout fires.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [CW-1:0]   r_cnt;

    logic            r_dm_req;
    logic            r_dm_we;
    logic [31:0]     r_dm_addr;
    logic [3:0]      r_dm_be;
    logic [31:0]     r_dm_wdata;

    logic            r_is_read;
    logic [2:0]      r_ld_f3;
    logic [1:0]      r_ld_lo;
    logic            r_err;
    logic [31:0]     r_ldata;

    logic            w_req;
    logic            w_illegal;
    logic            w_misalign;
    logic [1:0]      w_eff_lo;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [31:0]     w_ld_data;
    logic            w_go_req;
    logic            w_go_err;
    logic            w_ack;
    logic            w_tmo;

    assign w_req     = MemRead | MemWrite;
    assign w_illegal = (MemRead & MemWrite) | ~f3_legal(MemRead, Funct3);
    assign w_eff_lo  = eff_lo(Funct3, Addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = misaligned(Funct3, Addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    lsu_align u_align (
        .i_st_f3   (Funct3),
        .i_st_lo   (w_eff_lo),
        .i_st_read (MemRead),
        .i_wr_data (WrData),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .i_ld_f3   (r_ld_f3),
        .i_ld_lo   (r_ld_lo),
        .i_rd_data (DmRData),
        .o_ld_data (w_ld_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the one-cycle event strobes that drive the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_go_req    = 1'b0;
        w_go_err    = 1'b0;
        w_ack       = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_illegal | w_misalign) begin
                        w_state_nxt = DONE;
                        w_go_err    = 1'b1;
                    end else begin
                        w_state_nxt = REQ;
                        w_go_req    = 1'b1;
                    end
                end
            end
            REQ: begin
                if (DmAck) begin
                    w_state_nxt = DONE;
                    w_ack       = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DONE;
                    w_tmo       = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bus request registers, timeout counter and load-side capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= 32'h0;
            r_dm_be    <= 4'b0000;
            r_dm_wdata <= 32'h0;
            r_is_read  <= 1'b0;
            r_ld_f3    <= 3'b000;
            r_ld_lo    <= 2'b00;
        end else if (w_go_req) begin
            r_cnt      <= '0;
            r_dm_req   <= 1'b1;
            r_dm_we    <= MemWrite;
            r_dm_addr  <= {Addr[31:2], 2'b00};
            r_dm_be    <= w_be;
            r_dm_wdata <= w_wdata;
            r_is_read  <= MemRead;
            r_ld_f3    <= Funct3;
            r_ld_lo    <= w_eff_lo;
        end else if (r_state == REQ) begin
            if (w_ack | w_tmo) begin
                r_cnt      <= '0;
                r_dm_req   <= 1'b0;
                r_dm_we    <= 1'b0;
                r_dm_addr  <= 32'h0;
                r_dm_be    <= 4'b0000;
                r_dm_wdata <= 32'h0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Completion status: only non-zero while in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err   <= 1'b0;
            r_ldata <= 32'h0;
        end else if (w_go_err | w_tmo) begin
            r_err   <= 1'b1;
            r_ldata <= 32'h0;
        end else if (w_ack) begin
            r_err   <= 1'b0;
            r_ldata <= r_is_read ? w_ld_data : 32'h0;
        end else if (r_state == DONE) begin
            r_err   <= 1'b0;
            r_ldata <= 32'h0;
        end
    end

    // Stall is masked by reset so every output reads zero while reset is held.
    assign Stall    = ~rst & (((r_state == IDLE) & w_req) | (r_state == REQ));
    assign Done     = (r_state == DONE);
    assign LsuErr   = r_err;
    assign LoadData = r_ldata;
    assign DmReq    = r_dm_req;
    assign DmWe     = r_dm_we;
    assign DmAddr   = r_dm_addr;
    assign DmBe     = r_dm_be;
    assign DmWData  = r_dm_wdata;

endmodule
